// File: rtl/fhg_dummy_ep_pkg.sv
// Shared types and field offsets for the dummy endpoint (unpopulated-tile traffic terminator).
package fhg_dummy_ep_pkg;

    // Response code returned for every request packet.
    localparam logic [1:0] RspDecErr = 2'b11;

    typedef enum logic {
        HDR,
        BODY
    } state_e;

    // Header: dst_id at [IdWidth-1:0], src_id directly above it.
    function automatic int unsigned hdr_src_lsb(int unsigned id_width);
        return id_width;
    endfunction

    // Response: requester src_id at bit 0, own id above it, then the 2-bit code.
    function automatic int unsigned rsp_own_lsb(int unsigned id_width);
        return id_width;
    endfunction

    function automatic int unsigned rsp_code_lsb(int unsigned id_width);
        return 2 * id_width;
    endfunction

endpackage

// File: rtl/fhg_dummy_ep_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over a same-cycle increment.
module fhg_dummy_ep_sat_cnt #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o
);

    logic [Width-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != {Width{1'b1}})) begin
            cnt_q <= cnt_q + Width'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fhg_dummy_endpoint.sv
// Dummy eject endpoint: sinks all channels, answers channel-0 packets with DECERR responses.
// Optional statistics counters are built only when FHG_DUMMY_EP_STATS_EN is defined.
module fhg_dummy_endpoint
    import fhg_dummy_ep_pkg::*;
#(
    parameter int unsigned NumChannels  = 3,
    parameter int unsigned FlitWidth    = 64,
    parameter int unsigned IdWidth      = 6,
    parameter int unsigned RspFifoDepth = 4,
    parameter int unsigned CntWidth     = 16,
    parameter int unsigned RespondEn    = 1
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [IdWidth-1:0]              id_i,
    input  logic                            en_i,
    input  logic                            clear_i,
    input  logic [NumChannels-1:0]          in_valid_i,
    output logic [NumChannels-1:0]          in_ready_o,
    input  logic [NumChannels*FlitWidth-1:0] in_data_i,
    input  logic [NumChannels-1:0]          in_last_i,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic [FlitWidth-1:0]            rsp_data_o,
    output logic                            rsp_last_o,
    output logic [NumChannels*CntWidth-1:0] cnt_flit_o,
    output logic [NumChannels*CntWidth-1:0] cnt_pkt_o,
    output logic                            busy_o
);

    localparam int unsigned SrcLsb   = hdr_src_lsb(IdWidth);
    localparam int unsigned OwnLsb   = rsp_own_lsb(IdWidth);
    localparam int unsigned CodeLsb  = rsp_code_lsb(IdWidth);
    localparam int unsigned PtrWidth = (RspFifoDepth > 1) ? $clog2(RspFifoDepth) : 1;
    localparam int unsigned OccWidth = $clog2(RspFifoDepth + 1);
    localparam bit          RespEn   = (RespondEn != 0);

    state_e                state_q;
    logic                  rst_done_q;
    logic [PtrWidth-1:0]   wr_ptr_q;
    logic [PtrWidth-1:0]   rd_ptr_q;
    logic [OccWidth-1:0]   occ_q;
    logic [FlitWidth-1:0]  mem_q [RspFifoDepth];

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [NumChannels-1:0] ready;
    logic [NumChannels-1:0] accept;
    logic                   push;
    logic                   pop;
    logic [FlitWidth-1:0]   rsp_word;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] ptr);
        if (ptr == PtrWidth'(RspFifoDepth - 1)) begin
            return '0;
        end
        return ptr + PtrWidth'(1);
    endfunction

    assign fifo_full  = (occ_q == OccWidth'(RspFifoDepth));
    assign fifo_empty = (occ_q == '0);

    // Ready is built only from registered state and en_i; rst_done_q holds it low
    // for the first cycle after reset release.
    always_comb begin
        ready = {NumChannels{en_i & rst_done_q}};
        if ((state_q == HDR) && RespEn && fifo_full) begin
            ready[0] = 1'b0;
        end
    end

    assign in_ready_o = ready;
    assign accept     = in_valid_i & ready;
    assign push       = RespEn & accept[0] & (state_q == HDR);
    assign pop        = RespEn & ~fifo_empty & rsp_ready_i;

    always_comb begin
        rsp_word                      = '0;
        rsp_word[0 +: IdWidth]        = in_data_i[SrcLsb +: IdWidth];
        rsp_word[OwnLsb +: IdWidth]   = id_i;
        rsp_word[CodeLsb +: 2]        = RspDecErr;
    end

    // Channel-0 packet tracker: a last flit always lands in HDR, any other flit in BODY.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= HDR;
            rst_done_q <= 1'b0;
        end else begin
            rst_done_q <= 1'b1;
            if (accept[0]) begin
                state_q <= in_last_i[0] ? HDR : BODY;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (push && !pop) begin
                occ_q <= occ_q + OccWidth'(1);
            end else if (pop && !push) begin
                occ_q <= occ_q - OccWidth'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= rsp_word;
        end
    end

    assign rsp_valid_o = RespEn & ~fifo_empty;
    assign rsp_data_o  = rsp_valid_o ? mem_q[rd_ptr_q] : '0;
    assign rsp_last_o  = 1'b1;
    assign busy_o      = ~fifo_empty | (state_q == BODY);

`ifdef FHG_DUMMY_EP_STATS_EN
    for (genvar c = 0; c < NumChannels; c++) begin : g_cnt
        fhg_dummy_ep_sat_cnt #(
            .Width(CntWidth)
        ) u_flit_cnt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clear_i(clear_i),
            .inc_i  (accept[c]),
            .cnt_o  (cnt_flit_o[c*CntWidth +: CntWidth])
        );

        fhg_dummy_ep_sat_cnt #(
            .Width(CntWidth)
        ) u_pkt_cnt (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .clear_i(clear_i),
            .inc_i  (accept[c] & in_last_i[c]),
            .cnt_o  (cnt_pkt_o[c*CntWidth +: CntWidth])
        );
    end
`else
    assign cnt_flit_o = '0;
    assign cnt_pkt_o  = '0;
`endif

    // Sink payloads and, without statistics, last/clear are intentionally dropped.
    logic unused_in;
    assign unused_in = ^{in_data_i, in_last_i, clear_i};

endmodule
